// File: rtl/load_store_unit.sv
// load_store_unit: RV32 load/store engine between the core and a simple
// request/ack data bus. One access at a time, as an IDLE -> REQ -> DONE sequence.
//
// Ports
//   clk, reset         : rising-edge clock, asynchronous active-high reset
//   Mem_Read_i/Write_i : load/store request from the current instruction
//   Funct3_i           : access size/sign (B, H, W, BU, HU)
//   Address_i          : byte address from the ALU
//   Write_Data_i       : store data (rs2)
//   Load_Data_o        : formatted load result, valid in DONE only
//   Stall_o            : hold the core while an access is in flight
//   Misaligned_o       : misaligned access flag
//   Fault_o            : illegal Funct3_i or bus ack timeout
//   Bus_Req_o/We_o     : bus request and direction
//   Bus_Addr_o         : word-aligned bus address
//   Bus_Wdata_o/Be_o   : lane-replicated store data and byte enables
//   Bus_Ack_i/Rdata_i  : single-cycle completion pulse and read word
module load_store_unit #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Mem_Read_i,
  input  logic        Mem_Write_i,
  input  logic [2:0]  Funct3_i,
  input  logic [31:0] Address_i,
  input  logic [31:0] Write_Data_i,
  output logic [31:0] Load_Data_o,
  output logic        Stall_o,
  output logic        Misaligned_o,
  output logic        Fault_o,
  output logic        Bus_Req_o,
  output logic        Bus_We_o,
  output logic [31:0] Bus_Addr_o,
  output logic [31:0] Bus_Wdata_o,
  output logic [3:0]  Bus_Be_o,
  input  logic        Bus_Ack_i,
  input  logic [31:0] Bus_Rdata_i
);

  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      addr_q, wdata_q, load_q;
  logic [2:0]       f3_q;
  logic             we_q, timeout_q;
  logic [3:0]       be_q;

  logic        pending, is_load, illegal, misaligned, go, cnt_max;
  logic        stall_c, mis_c, flt_c;
  logic [31:0] lane_wdata, load_fmt;
  logic [3:0]  lane_be;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Request decode: a simultaneous read+write is treated as a load.
  always_comb begin
    pending    = Mem_Read_i | Mem_Write_i;
    is_load    = Mem_Read_i;
    if (is_load) illegal = !(Funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    else         illegal = !(Funct3_i inside {3'b000, 3'b001, 3'b010});
    // Funct3_i[1:0] == 01 covers both H and HU.
    misaligned = ((Funct3_i[1:0] == 2'b01) && Address_i[0]) ||
                 ((Funct3_i == 3'b010) && (Address_i[1:0] != 2'b00));
    go         = pending && !illegal && !misaligned;
  end

  // Store lane replication; loads read the full word.
  always_comb begin
    lane_wdata = 32'h0;
    lane_be    = 4'b1111;
    if (!is_load) begin
      case (Funct3_i[1:0])
        2'b00: begin
          lane_wdata = {4{Write_Data_i[7:0]}};
          lane_be    = 4'b0001 << Address_i[1:0];
        end
        2'b01: begin
          lane_wdata = {2{Write_Data_i[15:0]}};
          lane_be    = Address_i[1] ? 4'b1100 : 4'b0011;
        end
        default: lane_wdata = Write_Data_i;
      endcase
    end
  end

  // Load formatting from the latched byte offset and size.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    rd_byte = Bus_Rdata_i[7:0];
      2'd1:    rd_byte = Bus_Rdata_i[15:8];
      2'd2:    rd_byte = Bus_Rdata_i[23:16];
      default: rd_byte = Bus_Rdata_i[31:24];
    endcase
    rd_half = addr_q[1] ? Bus_Rdata_i[31:16] : Bus_Rdata_i[15:0];
    case (f3_q)
      3'b000:  load_fmt = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_fmt = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_fmt = {24'h0, rd_byte};
      3'b101:  load_fmt = {16'h0, rd_half};
      default: load_fmt = Bus_Rdata_i;
    endcase
  end

  assign cnt_max = (cnt == CNT_W'(ACK_TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and combinational status outputs.
  always_comb begin
    state_nxt = state;
    stall_c   = 1'b0;
    mis_c     = 1'b0;
    flt_c     = 1'b0;
    case (state)
      IDLE: begin
        if (pending) begin
          mis_c = misaligned;
          flt_c = illegal;
          if (go) begin
            stall_c   = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        stall_c = 1'b1;
        if (Bus_Ack_i || cnt_max) state_nxt = DONE;
      end
      DONE: begin
        flt_c     = timeout_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Access latches, ack-wait counter and load result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      be_q      <= 4'h0;
      f3_q      <= 3'h0;
      we_q      <= 1'b0;
      cnt       <= '0;
      timeout_q <= 1'b0;
      load_q    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            addr_q    <= Address_i;
            wdata_q   <= lane_wdata;
            be_q      <= lane_be;
            f3_q      <= Funct3_i;
            we_q      <= !is_load;
            cnt       <= '0;
            timeout_q <= 1'b0;
            load_q    <= 32'h0;
          end
        end
        REQ: begin
          if (Bus_Ack_i) begin
            if (!we_q) load_q <= load_fmt;
          end else if (cnt_max) begin
            timeout_q <= 1'b1;
            load_q    <= 32'h0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Reset gating keeps the IDLE decode outputs quiet while reset is held.
  assign Stall_o      = stall_c & ~reset;
  assign Misaligned_o = mis_c & ~reset;
  assign Fault_o      = flt_c & ~reset;
  assign Load_Data_o  = (state == DONE) ? load_q : 32'h0;
  assign Bus_Req_o    = (state == REQ);
  assign Bus_We_o     = we_q;
  assign Bus_Addr_o   = {addr_q[31:2], 2'b00};
  assign Bus_Wdata_o  = wdata_q;
  assign Bus_Be_o     = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads/stores, lane formatting,
// alignment and legality faults, ack timeout and reset mid-access.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        Mem_Read_i, Mem_Write_i;
  logic [2:0]  Funct3_i;
  logic [31:0] Address_i, Write_Data_i;
  logic [31:0] Load_Data_o;
  logic        Stall_o, Misaligned_o, Fault_o;
  logic        Bus_Req_o, Bus_We_o;
  logic [31:0] Bus_Addr_o, Bus_Wdata_o;
  logic [3:0]  Bus_Be_o;
  logic        Bus_Ack_i;
  logic [31:0] Bus_Rdata_i;

  int errors = 0;
  int checks = 0;

  load_store_unit #(.ACK_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .Mem_Read_i(Mem_Read_i), .Mem_Write_i(Mem_Write_i),
    .Funct3_i(Funct3_i), .Address_i(Address_i), .Write_Data_i(Write_Data_i),
    .Load_Data_o(Load_Data_o), .Stall_o(Stall_o),
    .Misaligned_o(Misaligned_o), .Fault_o(Fault_o),
    .Bus_Req_o(Bus_Req_o), .Bus_We_o(Bus_We_o),
    .Bus_Addr_o(Bus_Addr_o), .Bus_Wdata_o(Bus_Wdata_o), .Bus_Be_o(Bus_Be_o),
    .Bus_Ack_i(Bus_Ack_i), .Bus_Rdata_i(Bus_Rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    Mem_Read_i  = 1'b0;
    Mem_Write_i = 1'b0;
    Funct3_i    = 3'b000;
    Address_i   = 32'h0;
    Write_Data_i = 32'h0;
  endtask

  // Load with ack on the first REQ cycle; checks address and result.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] exp);
    Mem_Read_i = 1'b1; Funct3_i = f3; Address_i = addr;
    #1 chk1({tag, "_stall_idle"}, Stall_o, 1'b1);
    tick();
    idle_inputs();
    Bus_Ack_i = 1'b1; Bus_Rdata_i = rdata;
    #1 chk32({tag, "_addr"}, Bus_Addr_o, {addr[31:2], 2'b00});
    tick();
    Bus_Ack_i = 1'b0; Bus_Rdata_i = 32'h0;
    #1 chk32({tag, "_data"}, Load_Data_o, exp);
    chk1({tag, "_stall_done"}, Stall_o, 1'b0);
    tick();
  endtask

  initial begin
    // Reset with noisy inputs: outputs must already be zero.
    reset = 1'b1;
    Mem_Read_i = 1'b1; Mem_Write_i = 1'b0; Funct3_i = 3'b011;
    Address_i = 32'h101; Write_Data_i = 32'hFFFF_FFFF;
    Bus_Ack_i = 1'b0; Bus_Rdata_i = 32'h0;
    #3;
    chk1("rst_stall", Stall_o, 1'b0);
    chk1("rst_fault", Fault_o, 1'b0);
    chk1("rst_mis", Misaligned_o, 1'b0);
    chk1("rst_req", Bus_Req_o, 1'b0);
    chk1("rst_we", Bus_We_o, 1'b0);
    chk32("rst_load", Load_Data_o, 32'h0);
    chk32("rst_addr", Bus_Addr_o, 32'h0);
    chk32("rst_be", {28'h0, Bus_Be_o}, 32'h0);
    chk32("rst_wdata", Bus_Wdata_o, 32'h0);
    idle_inputs();
    tick(); tick();
    reset = 1'b0;
    tick();

    // LW 0x100, ack after 2 REQ cycles: stall for IDLE + 2 REQ cycles.
    Mem_Read_i = 1'b1; Funct3_i = 3'b010; Address_i = 32'h100;
    #1 chk1("lw_stall0", Stall_o, 1'b1);
    chk1("lw_req0", Bus_Req_o, 1'b0);
    tick();
    idle_inputs();
    #1 chk1("lw_req1", Bus_Req_o, 1'b1);
    chk1("lw_stall1", Stall_o, 1'b1);
    chk32("lw_addr", Bus_Addr_o, 32'h100);
    chk32("lw_be", {28'h0, Bus_Be_o}, 32'hF);
    chk1("lw_we", Bus_We_o, 1'b0);
    tick();
    Bus_Ack_i = 1'b1; Bus_Rdata_i = 32'hDEAD_BEEF;
    #1 chk1("lw_stall2", Stall_o, 1'b1);
    tick();
    Bus_Ack_i = 1'b0; Bus_Rdata_i = 32'h0;
    #1 chk32("lw_data", Load_Data_o, 32'hDEAD_BEEF);
    chk1("lw_stall_done", Stall_o, 1'b0);
    chk1("lw_req_done", Bus_Req_o, 1'b0);
    chk1("lw_fault_done", Fault_o, 1'b0);
    tick();
    chk32("lw_data_idle", Load_Data_o, 32'h0);

    // Lane select and sign/zero extension.
    do_load("lb",  3'b000, 32'h103, 32'h8011_2233, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 32'h103, 32'h8011_2233, 32'h0000_0080);
    do_load("lh",  3'b001, 32'h102, 32'h8011_2233, 32'hFFFF_8011);
    do_load("lhu", 3'b101, 32'h102, 32'h8011_2233, 32'h0000_8011);
    do_load("lb1", 3'b000, 32'h101, 32'h8011_2233, 32'h0000_0022);

    // SH 0x202: upper half lanes, bus stable while inputs change.
    Mem_Write_i = 1'b1; Funct3_i = 3'b001; Address_i = 32'h202; Write_Data_i = 32'h1234_ABCD;
    tick();
    Mem_Write_i = 1'b0; Address_i = 32'hFFFF_FFFF; Write_Data_i = 32'h0; Funct3_i = 3'b000;
    #1 chk32("sh_addr", Bus_Addr_o, 32'h200);
    chk32("sh_wdata", Bus_Wdata_o, 32'hABCD_ABCD);
    chk32("sh_be", {28'h0, Bus_Be_o}, 32'hC);
    chk1("sh_we", Bus_We_o, 1'b1);
    tick();
    Bus_Ack_i = 1'b1;
    #1 chk32("sh_addr_hold", Bus_Addr_o, 32'h200);
    chk32("sh_wdata_hold", Bus_Wdata_o, 32'hABCD_ABCD);
    tick();
    Bus_Ack_i = 1'b0;
    #1 chk32("sh_load_done", Load_Data_o, 32'h0);
    chk1("sh_stall_done", Stall_o, 1'b0);
    tick();
    idle_inputs();

    // SB 0x101: byte replicated, lane 1.
    Mem_Write_i = 1'b1; Funct3_i = 3'b000; Address_i = 32'h101; Write_Data_i = 32'h0000_77A5;
    tick();
    idle_inputs();
    Bus_Ack_i = 1'b1;
    #1 chk32("sb_wdata", Bus_Wdata_o, 32'hA5A5_A5A5);
    chk32("sb_be", {28'h0, Bus_Be_o}, 32'h2);
    tick();
    Bus_Ack_i = 1'b0;
    tick();

    // Misaligned LW: flagged, no stall, no bus request.
    Mem_Read_i = 1'b1; Funct3_i = 3'b010; Address_i = 32'h101;
    #1 chk1("mis_flag", Misaligned_o, 1'b1);
    chk1("mis_fault", Fault_o, 1'b0);
    chk1("mis_stall", Stall_o, 1'b0);
    chk32("mis_load", Load_Data_o, 32'h0);
    tick();
    chk1("mis_req", Bus_Req_o, 1'b0);
    idle_inputs();

    // Illegal load Funct3 011.
    Mem_Read_i = 1'b1; Funct3_i = 3'b011; Address_i = 32'h100;
    #1 chk1("ill_fault", Fault_o, 1'b1);
    chk1("ill_mis", Misaligned_o, 1'b0);
    chk1("ill_stall", Stall_o, 1'b0);
    tick();
    chk1("ill_req", Bus_Req_o, 1'b0);
    idle_inputs();

    // Store with a load-only Funct3 is illegal.
    Mem_Write_i = 1'b1; Funct3_i = 3'b100; Address_i = 32'h100;
    #1 chk1("ill_st_fault", Fault_o, 1'b1);
    tick();
    chk1("ill_st_req", Bus_Req_o, 1'b0);
    idle_inputs();

    // Read+write together acts as a load (BU accepted, We low).
    Mem_Read_i = 1'b1; Mem_Write_i = 1'b1; Funct3_i = 3'b100; Address_i = 32'h100;
    #1 chk1("rw_stall", Stall_o, 1'b1);
    tick();
    idle_inputs();
    Bus_Ack_i = 1'b1; Bus_Rdata_i = 32'h0000_00F0;
    #1 chk1("rw_we", Bus_We_o, 1'b0);
    tick();
    Bus_Ack_i = 1'b0;
    #1 chk32("rw_data", Load_Data_o, 32'h0000_00F0);
    tick();

    // No ack: fault after 16 REQ cycles.
    Mem_Read_i = 1'b1; Funct3_i = 3'b010; Address_i = 32'h300;
    tick();
    idle_inputs();
    for (int i = 0; i < 16; i++) begin
      chk1("to_req", Bus_Req_o, 1'b1);
      tick();
    end
    chk1("to_fault", Fault_o, 1'b1);
    chk1("to_req_done", Bus_Req_o, 1'b0);
    chk1("to_stall", Stall_o, 1'b0);
    chk32("to_load", Load_Data_o, 32'h0);
    Bus_Ack_i = 1'b1; Bus_Rdata_i = 32'h1234_5678;
    tick();
    chk1("to_fault_idle", Fault_o, 1'b0);
    chk1("to_req_idle", Bus_Req_o, 1'b0);
    tick();
    // Ack seen in DONE/IDLE must not start anything.
    chk1("ack_ignored_req", Bus_Req_o, 1'b0);
    chk32("ack_ignored_load", Load_Data_o, 32'h0);
    Bus_Ack_i = 1'b0;

    // Reset pulsed during REQ, then a late ack.
    Mem_Read_i = 1'b1; Funct3_i = 3'b010; Address_i = 32'h400;
    tick();
    idle_inputs();
    chk1("rr_req", Bus_Req_o, 1'b1);
    #2 reset = 1'b1;
    #1 chk1("rr_req_drop", Bus_Req_o, 1'b0);
    chk1("rr_stall", Stall_o, 1'b0);
    chk32("rr_addr", Bus_Addr_o, 32'h0);
    #1 reset = 1'b0;
    tick();
    Bus_Ack_i = 1'b1; Bus_Rdata_i = 32'hCAFE_F00D;
    #1 chk1("rr_req_idle", Bus_Req_o, 1'b0);
    tick();
    Bus_Ack_i = 1'b0;
    chk32("rr_load", Load_Data_o, 32'h0);
    chk1("rr_stall_late", Stall_o, 1'b0);
    chk1("rr_req_late", Bus_Req_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ACK_TIMEOUT, default 16, SHALL set the maximum number of REQ-state cycles spent waiting for Bus_Ack_i before a fault.
REQ-002 Clocking SHALL be: one clock; reset is asynchronous and active-high.
REQ-003 Ports SHALL be, in this order:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous active-high reset.
- Mem_Read_i  in  1  load requested by the current instruction.
- Mem_Write_i  in  1  store requested by the current instruction.
- Funct3_i  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- Address_i  in  32  byte address, the ALU result.
- Write_Data_i  in  32  store data (rs2).
- Load_Data_o  out  32  formatted load result.
- Stall_o  out  1  hold PC/core this cycle.
- Misaligned_o  out  1  misaligned access flag.
- Fault_o  out  1  illegal Funct3_i or bus timeout flag.
- Bus_Req_o  out  1  bus request.
- Bus_We_o  out  1  1 = write.
- Bus_Addr_o  out  32  word-aligned address, with [1:0] = 00.
- Bus_Wdata_o  out  32  lane-replicated write data.
- Bus_Be_o  out  4  byte enables.
- Bus_Ack_i  in  1  bus completion, single-cycle pulse.
- Bus_Rdata_i  in  32  read word, valid when Bus_Ack_i = 1.

Function
REQ-004 The FSM SHALL have three states: IDLE, REQ and DONE.
REQ-005 In IDLE, an access SHALL be pending when Mem_Read_i or Mem_Write_i is 1; if both are 1, the access SHALL be a load.
REQ-006 Alignment SHALL be checked as follows: H/HU with Address_i[0] = 1 is misaligned, and W with Address_i[1:0] != 00 is misaligned.
REQ-007 Funct3_i legality SHALL be checked as follows: loads accept 000, 001, 010, 100 and 101; stores accept 000, 001 and 010; any other value is illegal.
REQ-008 For a pending access that is misaligned or illegal, all of the following SHALL hold:
- No bus access occurs.
- In the same cycle, Misaligned_o or Fault_o is 1 combinationally.
- Stall_o = 0 and Load_Data_o = 0.
- The FSM stays in IDLE.
REQ-009 For a valid pending access in IDLE:
- Stall_o SHALL be 1 combinationally.
- At the next edge, the address, Funct3_i, the write data and the direction SHALL be latched, and the FSM SHALL move to REQ.
REQ-010 In REQ, Bus_Req_o = 1 and Stall_o = 1; all Bus_* outputs SHALL be driven only from the latched registers and SHALL stay stable until ack.
REQ-011 In REQ, when Bus_Ack_i = 1 at an edge, the FSM SHALL go to DONE, and for a load the formatted Bus_Rdata_i SHALL be registered into Load_Data_o.
REQ-012 In REQ, a cycle counter SHALL start at 0 on entry; if it reaches ACK_TIMEOUT without ack, the FSM SHALL go to DONE with Fault_o = 1 for the DONE cycle and Load_Data_o = 0.
REQ-013 In DONE, Stall_o = 0, Bus_Req_o = 0 and Load_Data_o is held; the next edge SHALL return the FSM to IDLE.
REQ-014 Minimum latency SHALL be 3 cycles, ack at the first REQ edge; each extra ack wait SHALL add 1 cycle.
REQ-015 Bus_Ack_i SHALL be ignored in IDLE and DONE.
REQ-016 Store lanes SHALL be formed as follows:
- SB: Bus_Wdata_o = the byte repeated 4 times, and Bus_Be_o = 0001 shifted left by addr[1:0].
- SH: the halfword repeated 2 times, with Bus_Be_o = 0011 for addr[1] = 0 or 1100 for addr[1] = 1.
- SW: Bus_Be_o = 1111.
REQ-017 For loads, Bus_Be_o SHALL be 1111 and Bus_We_o = 0.
REQ-018 Load formatting SHALL select the lane by the latched addr[1:0]; B/H SHALL sign-extend, BU/HU SHALL zero-extend, and W SHALL pass the word through.
REQ-019 Outside DONE, Load_Data_o SHALL be 0; Misaligned_o and Fault_o SHALL be 0 except as defined above.

Reset
REQ-020 While reset = 1, the following SHALL hold immediately, without waiting for clk:
- The FSM is in IDLE and the counter and latches are 0.
- Load_Data_o = 0, and Bus_Addr_o, Bus_Wdata_o and Bus_Be_o = 0.
- Bus_Req_o = 0 and Bus_We_o = 0.
- Stall_o, Misaligned_o and Fault_o = 0.
REQ-021 Reset asserted during REQ SHALL abandon the access; a late Bus_Ack_i after release SHALL be ignored.

Verification
REQ-022 LW, Address_i = 0x100, Bus_Rdata_i = 0xDEADBEEF, ack after 2 REQ cycles -> Bus_Addr_o = 0x100, Stall_o high for 3 cycles, Load_Data_o = 0xDEADBEEF in DONE.
REQ-023 LB at 0x103 and LBU at 0x103, Bus_Rdata_i = 0x80112233 -> Load_Data_o = 0xFFFFFF80 and 0x00000080 respectively.
REQ-024 SH at 0x202, Write_Data_i = 0x1234ABCD -> Bus_Addr_o = 0x200, Bus_Wdata_o = 0xABCDABCD, Bus_Be_o = 1100, Bus_We_o = 1.
REQ-025 LW at 0x101, and separately a load with Funct3_i = 011 -> Misaligned_o = 1 and Fault_o = 1 respectively, with Bus_Req_o never asserted and Stall_o = 0.
REQ-026 Load with no ack -> Fault_o = 1 after ACK_TIMEOUT = 16 REQ cycles, Load_Data_o = 0, FSM back to IDLE next cycle.
REQ-027 Reset pulsed during REQ with a late ack -> Bus_Req_o drops without waiting for clk, FSM stays in IDLE, Load_Data_o = 0.
